// File: rtl/ibex_prefetch_ctrl.sv
// Instruction prefetch controller: issues word fetches on a req/gnt/rvalid bus,
// pushes responses into the fetch FIFO and discards stale responses after a redirect.
module ibex_prefetch_ctrl #(
   parameter int unsigned NUM_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        fifo_clear_o,
   output logic        fifo_valid_o,
   output logic [31:0] fifo_addr_o,
   output logic [31:0] fifo_rdata_o,
   input  logic        fifo_ready_i,
   output logic        err_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP
   } state_e;

   localparam logic [2:0] MaxOut = 3'(NUM_OUTSTANDING);

   state_e      state_q, state_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] push_addr_q, push_addr_d;
   logic [31:0] redir_addr_q, redir_addr_d;
   logic        redir_pend_q, redir_pend_d;
   logic        stale_req_q, stale_req_d;
   logic        err_q, err_d;
   logic [1:0]  outstanding_q, outstanding_d;
   logic [1:0]  discard_q, discard_d;

   logic        gnt_fire;
   logic        rsp_live;
   logic        push;
   logic        err_set;
   logic        can_issue;
   logic        issue_now;
   logic        issue_after_gnt;
   logic [31:0] branch_word;

   assign branch_word = {branch_addr_i[31:2], 2'b00};
   assign gnt_fire    = (state_q == REQ) & instr_gnt_i;

   // A response is only live when nothing stale is pending, no redirect is in
   // progress and no earlier error has frozen the stream.
   assign rsp_live = instr_rvalid_i & (discard_q == 2'd0) & ~branch_i & ~err_q;
   assign push     = rsp_live & ~instr_err_i;
   assign err_set  = rsp_live & instr_err_i;

   assign err_d         = branch_i ? 1'b0 : (err_q | err_set);
   assign outstanding_d = outstanding_q + {1'b0, gnt_fire} - {1'b0, instr_rvalid_i};

   assign can_issue       = fetch_en_i & fifo_ready_i & ~err_d;
   assign issue_now       = can_issue & ({1'b0, outstanding_q} < MaxOut);
   assign issue_after_gnt = can_issue & (({1'b0, outstanding_q} + 3'd1) < MaxOut);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      push_addr_d  = push_addr_q;
      redir_addr_d = redir_addr_q;
      redir_pend_d = redir_pend_q;
      stale_req_d  = stale_req_q;
      discard_d    = discard_q;

      unique case (state_q)
         IDLE: begin
            if (issue_now) state_d = REQ;
         end
         REQ: begin
            if (gnt_fire) begin
               fetch_addr_d = redir_pend_q ? redir_addr_q : fetch_addr_q + 32'd4;
               redir_pend_d = 1'b0;
               stale_req_d  = 1'b0;
               if (issue_after_gnt)              state_d = REQ;
               else if (outstanding_d != 2'd0)   state_d = WAIT_RSP;
               else                              state_d = IDLE;
            end
         end
         WAIT_RSP: begin
            if (issue_now)                   state_d = REQ;
            else if (outstanding_d == 2'd0)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (instr_rvalid_i && discard_q != 2'd0) discard_d = discard_d - 2'd1;
      if (gnt_fire && stale_req_q)             discard_d = discard_d + 2'd1;
      if (push) push_addr_d = {push_addr_q[31:2] + 30'd1, 2'b00};

      // A redirect while a request is still ungranted keeps that request on the
      // bus; its eventual response is counted stale and the new target waits.
      if (branch_i) begin
         discard_d   = outstanding_d;
         push_addr_d = branch_addr_i;
         if (state_q == REQ && !instr_gnt_i) begin
            redir_pend_d = 1'b1;
            redir_addr_d = branch_word;
            stale_req_d  = 1'b1;
         end else begin
            fetch_addr_d = branch_word;
            redir_pend_d = 1'b0;
            stale_req_d  = 1'b0;
            if (state_q != REQ && issue_now) state_d = REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         fetch_addr_q  <= '0;
         push_addr_q   <= '0;
         redir_addr_q  <= '0;
         redir_pend_q  <= 1'b0;
         stale_req_q   <= 1'b0;
         err_q         <= 1'b0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers
         // update together from the values sampled at this edge.
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         push_addr_q   <= push_addr_d;
         redir_addr_q  <= redir_addr_d;
         redir_pend_q  <= redir_pend_d;
         stale_req_q   <= stale_req_d;
         err_q         <= err_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   assign instr_req_o  = (state_q == REQ);
   assign instr_addr_o = fetch_addr_q;
   assign fifo_clear_o = branch_i;
   assign fifo_valid_o = push;
   assign fifo_addr_o  = push_addr_q;
   assign fifo_rdata_o = instr_rdata_i;
   assign err_o        = err_q;
   assign busy_o       = (outstanding_q != 2'd0) | instr_req_o;

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Directed bench for ibex_prefetch_ctrl: each task scripts bus/FIFO inputs cycle
// by cycle and compares outputs #1 after the inputs change, away from posedge.
module tb_ibex_prefetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] branch_addr_i = '0;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        instr_err_i = 1'b0;
   logic        fifo_clear_o;
   logic        fifo_valid_o;
   logic [31:0] fifo_addr_o;
   logic [31:0] fifo_rdata_o;
   logic        fifo_ready_i = 1'b0;
   logic        err_o;
   logic        busy_o;

   int total = 0;
   int bad   = 0;

   ibex_prefetch_ctrl #(.NUM_OUTSTANDING(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_en_i    (fetch_en_i),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .instr_req_o   (instr_req_o),
      .instr_addr_o  (instr_addr_o),
      .instr_gnt_i   (instr_gnt_i),
      .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i (instr_rdata_i),
      .instr_err_i   (instr_err_i),
      .fifo_clear_o  (fifo_clear_o),
      .fifo_valid_o  (fifo_valid_o),
      .fifo_addr_o   (fifo_addr_o),
      .fifo_rdata_o  (fifo_rdata_o),
      .fifo_ready_i  (fifo_ready_i),
      .err_o         (err_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Applies one cycle of inputs at the falling edge and settles for 1 time unit.
   task automatic drive(input logic r, en, rdy, gnt, rv, er, br,
                        input logic [31:0] baddr, rdata);
      @(negedge clk);
      rst = r; fetch_en_i = en; fifo_ready_i = rdy; instr_gnt_i = gnt;
      instr_rvalid_i = rv; instr_err_i = er; branch_i = br;
      branch_addr_i = baddr; instr_rdata_i = rdata;
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o, fifo_valid_o, fifo_clear_o, err_o, busy_o} !== 37'h0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0",
                  {instr_req_o, instr_addr_o, fifo_valid_o, fifo_clear_o, err_o, busy_o});
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp_addr [3];
      exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if (instr_req_o !== 1'b0) begin bad++; $display("FAIL stream_idle_req: got %b want 0", instr_req_o); end
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o, busy_o} !== {1'b1, exp_addr[0], 1'b1}) begin
         bad++; $display("FAIL stream_req0: got %h want %h", {instr_req_o, instr_addr_o, busy_o}, {1'b1, exp_addr[0], 1'b1});
      end
      drive(0, 1, 1, 1, 1, 0, 0, 0, dat(32'h0));
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, exp_addr[1]}) begin
         bad++; $display("FAIL stream_req4: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, exp_addr[1]});
      end
      total++;
      if ({fifo_valid_o, fifo_addr_o, fifo_rdata_o} !== {1'b1, 32'h0, dat(32'h0)}) begin
         bad++; $display("FAIL stream_push0: got %h want %h", {fifo_valid_o, fifo_addr_o, fifo_rdata_o}, {1'b1, 32'h0, dat(32'h0)});
      end
      drive(0, 1, 1, 1, 1, 0, 0, 0, dat(32'h4));
      total++;
      if ({instr_req_o, busy_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o} !== {3'b011, 32'h4, dat(32'h4)}) begin
         bad++; $display("FAIL stream_push4_full: got %h want %h", {instr_req_o, busy_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o}, {3'b011, 32'h4, dat(32'h4)});
      end
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o, fifo_valid_o} !== {1'b1, exp_addr[2], 1'b0}) begin
         bad++; $display("FAIL stream_req8: got %h want %h", {instr_req_o, instr_addr_o, fifo_valid_o}, {1'b1, exp_addr[2], 1'b0});
      end
      drive(0, 0, 1, 1, 1, 0, 0, 0, dat(32'h8));
      total++;
      if ({instr_req_o, instr_addr_o, fifo_valid_o, fifo_addr_o} !== {1'b1, 32'hC, 1'b1, 32'h8}) begin
         bad++; $display("FAIL stream_reqC_push8: got %h want %h", {instr_req_o, instr_addr_o, fifo_valid_o, fifo_addr_o}, {1'b1, 32'hC, 1'b1, 32'h8});
      end
      drive(0, 0, 1, 0, 1, 0, 0, 0, dat(32'hC));
      total++;
      if ({instr_req_o, busy_o, fifo_valid_o, fifo_addr_o} !== {3'b011, 32'hC}) begin
         bad++; $display("FAIL stream_pushC: got %h want %h", {instr_req_o, busy_o, fifo_valid_o, fifo_addr_o}, {3'b011, 32'hC});
      end
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, busy_o} !== 2'b00) begin bad++; $display("FAIL stream_drain: got %b want 00", {instr_req_o, busy_o}); end
   endtask

   task automatic test_gnt_stall();
      drive(0, 1, 1, 0, 0, 0, 1, 32'h100, 0);
      total++;
      if ({fifo_clear_o, instr_req_o} !== 2'b10) begin bad++; $display("FAIL stall_branch: got %b want 10", {fifo_clear_o, instr_req_o}); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
         total++;
         if ({instr_req_o, instr_addr_o, busy_o} !== {1'b1, 32'h100, 1'b1}) begin
            bad++; $display("FAIL stall_hold%0d: got %h want %h", i, {instr_req_o, instr_addr_o, busy_o}, {1'b1, 32'h100, 1'b1});
         end
      end
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h100}) begin
         bad++; $display("FAIL stall_grant: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h100});
      end
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, busy_o} !== 2'b01) begin bad++; $display("FAIL stall_wait: got %b want 01", {instr_req_o, busy_o}); end
      drive(0, 0, 1, 0, 1, 0, 0, 0, dat(32'h100));
      total++;
      if ({fifo_valid_o, fifo_addr_o, fifo_rdata_o} !== {1'b1, 32'h100, dat(32'h100)}) begin
         bad++; $display("FAIL stall_push: got %h want %h", {fifo_valid_o, fifo_addr_o, fifo_rdata_o}, {1'b1, 32'h100, dat(32'h100)});
      end
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_single_count: got busy=%b want 0", busy_o); end
   endtask

   task automatic test_branch_flush();
      drive(0, 1, 1, 0, 0, 0, 1, 32'h10, 0);
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h10}) begin
         bad++; $display("FAIL flush_req10: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h10});
      end
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h14}) begin
         bad++; $display("FAIL flush_req14: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h14});
      end
      drive(0, 1, 1, 0, 0, 0, 1, 32'h202, 0);
      total++;
      if ({fifo_clear_o, instr_req_o, busy_o, fifo_valid_o} !== 4'b1010) begin
         bad++; $display("FAIL flush_branch: got %b want 1010", {fifo_clear_o, instr_req_o, busy_o, fifo_valid_o});
      end
      drive(0, 1, 1, 0, 1, 0, 0, 0, dat(32'h10));
      total++;
      if ({fifo_valid_o, fifo_clear_o, instr_req_o} !== 3'b000) begin
         bad++; $display("FAIL flush_drop1: got %b want 000", {fifo_valid_o, fifo_clear_o, instr_req_o});
      end
      drive(0, 1, 1, 0, 1, 0, 0, 0, dat(32'h14));
      total++;
      if ({fifo_valid_o, instr_req_o} !== 2'b00) begin bad++; $display("FAIL flush_drop2: got %b want 00", {fifo_valid_o, instr_req_o}); end
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h200}) begin
         bad++; $display("FAIL flush_req200: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h200});
      end
      drive(0, 0, 1, 1, 1, 0, 0, 0, dat(32'h200));
      total++;
      if ({instr_req_o, instr_addr_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o} !== {1'b1, 32'h204, 1'b1, 32'h202, dat(32'h200)}) begin
         bad++; $display("FAIL flush_push202: got %h want %h", {instr_req_o, instr_addr_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o}, {1'b1, 32'h204, 1'b1, 32'h202, dat(32'h200)});
      end
      drive(0, 0, 1, 0, 1, 0, 0, 0, dat(32'h204));
      total++;
      if ({fifo_valid_o, fifo_addr_o} !== {1'b1, 32'h204}) begin
         bad++; $display("FAIL flush_push204: got %h want %h", {fifo_valid_o, fifo_addr_o}, {1'b1, 32'h204});
      end
   endtask

   task automatic test_fifo_ready();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
         total++;
         if ({instr_req_o, busy_o} !== 2'b00) begin bad++; $display("FAIL ready_block%0d: got %b want 00", i, {instr_req_o, busy_o}); end
      end
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if (instr_req_o !== 1'b0) begin bad++; $display("FAIL ready_rise_same: got %b want 0", instr_req_o); end
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h208}) begin
         bad++; $display("FAIL ready_req208: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h208});
      end
      drive(0, 0, 1, 0, 1, 0, 0, 0, dat(32'h208));
      total++;
      if ({fifo_valid_o, fifo_addr_o} !== {1'b1, 32'h208}) begin
         bad++; $display("FAIL ready_push208: got %h want %h", {fifo_valid_o, fifo_addr_o}, {1'b1, 32'h208});
      end
   endtask

   task automatic test_error();
      drive(0, 1, 1, 0, 0, 0, 1, 32'h40, 0);
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h40}) begin
         bad++; $display("FAIL err_req40: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h40});
      end
      drive(0, 1, 1, 0, 1, 1, 0, 0, dat(32'h40));
      total++;
      if ({fifo_valid_o, err_o} !== 2'b00) begin bad++; $display("FAIL err_rsp_nopush: got %b want 00", {fifo_valid_o, err_o}); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
         total++;
         if ({err_o, instr_req_o} !== 2'b10) begin bad++; $display("FAIL err_blocked%0d: got %b want 10", i, {err_o, instr_req_o}); end
      end
      drive(0, 1, 1, 0, 0, 0, 1, 32'h80, 0);
      total++;
      if ({fifo_clear_o, err_o} !== 2'b11) begin bad++; $display("FAIL err_branch: got %b want 11", {fifo_clear_o, err_o}); end
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o, err_o} !== {1'b1, 32'h80, 1'b0}) begin
         bad++; $display("FAIL err_resume: got %h want %h", {instr_req_o, instr_addr_o, err_o}, {1'b1, 32'h80, 1'b0});
      end
      drive(0, 0, 1, 0, 1, 0, 0, 0, dat(32'h80));
      total++;
      if ({fifo_valid_o, fifo_addr_o} !== {1'b1, 32'h80}) begin
         bad++; $display("FAIL err_push80: got %h want %h", {fifo_valid_o, fifo_addr_o}, {1'b1, 32'h80});
      end
   endtask

   task automatic test_reset_mid_burst();
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h84}) begin
         bad++; $display("FAIL midrst_req84: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h84});
      end
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, busy_o} !== 2'b01) begin bad++; $display("FAIL midrst_two_out: got %b want 01", {instr_req_o, busy_o}); end
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o, fifo_valid_o, fifo_clear_o, err_o, busy_o, fifo_addr_o} !== 69'h0) begin
         bad++; $display("FAIL midrst_cleared: got %h want 0", {instr_req_o, instr_addr_o, fifo_valid_o, fifo_clear_o, err_o, busy_o, fifo_addr_o});
      end
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h0}) begin
         bad++; $display("FAIL midrst_restart: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h0});
      end
   endtask

   task automatic test_branch_during_req();
      drive(0, 1, 1, 0, 0, 0, 1, 32'h300, 0);
      total++;
      if ({instr_req_o, instr_addr_o, fifo_clear_o} !== {1'b1, 32'h0, 1'b1}) begin
         bad++; $display("FAIL brq_branch: got %h want %h", {instr_req_o, instr_addr_o, fifo_clear_o}, {1'b1, 32'h0, 1'b1});
      end
      drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
      total++;
      if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h0}) begin
         bad++; $display("FAIL brq_held: got %h want %h", {instr_req_o, instr_addr_o}, {1'b1, 32'h0});
      end
      drive(0, 0, 1, 1, 1, 0, 0, 0, dat(32'h0));
      total++;
      if ({instr_req_o, instr_addr_o, fifo_valid_o} !== {1'b1, 32'h300, 1'b0}) begin
         bad++; $display("FAIL brq_stale_drop: got %h want %h", {instr_req_o, instr_addr_o, fifo_valid_o}, {1'b1, 32'h300, 1'b0});
      end
      drive(0, 0, 1, 0, 1, 0, 0, 0, dat(32'h300));
      total++;
      if ({fifo_valid_o, fifo_addr_o, fifo_rdata_o} !== {1'b1, 32'h300, dat(32'h300)}) begin
         bad++; $display("FAIL brq_push300: got %h want %h", {fifo_valid_o, fifo_addr_o, fifo_rdata_o}, {1'b1, 32'h300, dat(32'h300)});
      end
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL brq_idle: got busy=%b want 0", busy_o); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_gnt_stall();
      test_branch_flush();
      test_fifo_ready();
      test_error();
      test_reset_mid_burst();
      test_branch_during_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
